// File: rtl/tone_square_gen.sv
// Square-wave tone generator: turns a frequency in Hz into a period with a
// sequential restoring divider and plays it, swapping periods only at period edges.
module tone_square_gen #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned MAX_FREQ  = 20000,
    parameter int unsigned DUTY_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [31:0]          tone,
    input  logic [DUTY_BITS-1:0] duty,
    output logic                 pwm,
    output logic                 busy,
    output logic                 note_on
);

    localparam logic [31:0] DIVIDEND = 32'(CLK_FREQ);
    localparam logic [31:0] MAX_TONE = 32'(MAX_FREQ);
    localparam int          PW       = 32 + DUTY_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] tone_q, tone_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  bit_q, bit_d;
    logic        restart_q, restart_d;
    logic [31:0] period_pend_q, period_pend_d;
    logic        pending_valid_q, pending_valid_d;
    logic [31:0] period_act_q, period_act_d;
    logic [31:0] high_act_q, high_act_d;
    logic [31:0] cnt_q, cnt_d;
    logic        pwm_q, pwm_d;
    logic        busy_q, busy_d;
    logic        note_on_q, note_on_d;

    logic        silent_s;
    logic        changed_s;
    logic        audible_chg_s;
    logic        silent_chg_s;
    logic [32:0] rem_sh_s;
    logic        ge_s;
    logic        wr_s;
    logic [31:0] wr_val_s;
    logic        pv_eff_s;
    logic [31:0] pend_eff_s;
    logic        wrap_s;
    logic        apply_s;

    function automatic logic [31:0] high_time(input logic [31:0] period,
                                              input logic [DUTY_BITS-1:0] frac);
        return 32'(({{DUTY_BITS{1'b0}}, period} * {32'd0, frac}) >> DUTY_BITS);
    endfunction

    // Tone classification and one restoring-divide step
    always_comb begin
        silent_s      = (tone == 32'd0) || (tone >= MAX_TONE);
        changed_s     = (tone != tone_q);
        audible_chg_s = changed_s && !silent_s;
        silent_chg_s  = changed_s && silent_s;
        rem_sh_s      = {rem_q, dvd_q[31]};
        ge_s          = (rem_sh_s >= {1'b0, tone_q});
    end

    // Divider FSM; a silent code cancels any divide and queues silence directly
    always_comb begin
        state_d   = state_q;
        tone_d    = tone_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        bit_d     = bit_q;
        restart_d = restart_q;
        wr_s      = 1'b0;
        wr_val_s  = period_pend_q;
        if (silent_chg_s) begin
            tone_d    = tone;
            state_d   = ST_IDLE;
            restart_d = 1'b0;
            wr_s      = 1'b1;
            wr_val_s  = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (audible_chg_s) begin
                        tone_d    = tone;
                        state_d   = ST_DIV;
                        dvd_d     = DIVIDEND;
                        rem_d     = 32'd0;
                        bit_d     = 5'd0;
                        restart_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DIV: begin
                    dvd_d = {dvd_q[30:0], ge_s};
                    rem_d = ge_s ? 32'(rem_sh_s - {1'b0, tone_q}) : rem_sh_s[31:0];
                    bit_d = bit_q + 5'd1;
                    if (bit_q == 5'd31) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                    if (audible_chg_s) begin
                        restart_d = 1'b1;
                    end else begin
                        restart_d = restart_q;
                    end
                end
                ST_DONE: begin
                    // A tone that moved during the divide makes this quotient stale
                    if (restart_q || audible_chg_s) begin
                        restart_d = 1'b0;
                        tone_d    = tone;
                        state_d   = ST_DIV;
                        dvd_d     = DIVIDEND;
                        rem_d     = 32'd0;
                        bit_d     = 5'd0;
                    end else begin
                        wr_s     = 1'b1;
                        wr_val_s = dvd_q;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Pending-to-active transfer and period counter
    always_comb begin
        pv_eff_s        = pending_valid_q || wr_s;
        pend_eff_s      = wr_s ? wr_val_s : period_pend_q;
        wrap_s          = (period_act_q != 32'd0) && (cnt_q == period_act_q - 32'd1);
        apply_s         = pv_eff_s && ((period_act_q == 32'd0) || !en || wrap_s);
        period_pend_d   = pend_eff_s;
        pending_valid_d = pv_eff_s;
        period_act_d    = period_act_q;
        high_act_d      = high_act_q;
        cnt_d           = 32'd0;
        if (apply_s) begin
            period_act_d    = pend_eff_s;
            high_act_d      = high_time(pend_eff_s, duty);
            pending_valid_d = 1'b0;
        end else if ((period_act_q != 32'd0) && en) begin
            cnt_d = wrap_s ? 32'd0 : cnt_q + 32'd1;
        end else begin
            cnt_d = 32'd0;
        end
        pwm_d     = en && (period_act_q != 32'd0) && (cnt_q < high_act_q);
        busy_d    = (state_d == ST_DIV) || ((state_d == ST_DONE) && restart_d);
        note_on_d = (period_act_d != 32'd0);
    end

    // State registers with asynchronous reset to silence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            tone_q          <= 32'd0;
            dvd_q           <= 32'd0;
            rem_q           <= 32'd0;
            bit_q           <= 5'd0;
            restart_q       <= 1'b0;
            period_pend_q   <= 32'd0;
            pending_valid_q <= 1'b0;
            period_act_q    <= 32'd0;
            high_act_q      <= 32'd0;
            cnt_q           <= 32'd0;
            pwm_q           <= 1'b0;
            busy_q          <= 1'b0;
            note_on_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            tone_q          <= tone_d;
            dvd_q           <= dvd_d;
            rem_q           <= rem_d;
            bit_q           <= bit_d;
            restart_q       <= restart_d;
            period_pend_q   <= period_pend_d;
            pending_valid_q <= pending_valid_d;
            period_act_q    <= period_act_d;
            high_act_q      <= high_act_d;
            cnt_q           <= cnt_d;
            pwm_q           <= pwm_d;
            busy_q          <= busy_d;
            note_on_q       <= note_on_d;
        end
    end

    assign pwm     = pwm_q;
    assign busy    = busy_q;
    assign note_on = note_on_q;

endmodule

// File: tb/tb_tone_square_gen.sv
// Directed bench for tone_square_gen, run with a 1 MHz clock parameter so
// whole tone periods stay short (440 Hz -> 2272 cycles).
module tb_tone_square_gen;

    localparam int LIMIT = 6000;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] tone;
    logic [9:0]  duty;
    logic        pwm;
    logic        busy;
    logic        note_on;

    int passed;
    int failed;
    int total;

    tone_square_gen #(
        .CLK_FREQ (1000000),
        .MAX_FREQ (20000),
        .DUTY_BITS(10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .tone   (tone),
        .duty   (duty),
        .pwm    (pwm),
        .busy   (busy),
        .note_on(note_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pwm(input logic lvl);
        int n;
        n = 0;
        while (pwm !== lvl && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_pwm(input logic lvl, output int n);
        n = 0;
        while (pwm === lvl && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_busy_high();
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_busy(output int n);
        wait_busy_high();
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    int hi;
    int lo;
    int n;
    int seen;

    initial begin
        passed = 0;
        failed = 0;
        total  = 0;
        rst  = 1'b1;
        en   = 1'b0;
        tone = 32'd0;
        duty = 10'd0;
        repeat (3) @(negedge clk);
        check("reset_pwm", pwm, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_note_on", note_on, 1'b0);
        check("reset_period_act", dut.period_act_q, 32'd0);

        // 440 Hz at 50 % duty
        rst  = 1'b0;
        en   = 1'b1;
        duty = 10'd512;
        tone = 32'd440;
        count_busy(n);
        check("busy_len_440", n, 32);
        wait_pwm(1'b1);
        check("note_on_440", note_on, 1'b1);
        check("period_440", dut.period_act_q, 32'd2272);
        check("high_440", dut.high_act_q, 32'd1136);
        count_pwm(1'b1, hi);
        count_pwm(1'b0, lo);
        check("hi_440", hi, 1136);
        check("lo_440", lo, 1136);

        // Change to 523 Hz mid high phase: current period finishes intact
        repeat (100) @(negedge clk);
        tone = 32'd523;
        count_pwm(1'b1, hi);
        count_pwm(1'b0, lo);
        check("lo_440_tail", lo, 1136);
        count_pwm(1'b1, hi);
        count_pwm(1'b0, lo);
        check("hi_523", hi, 956);
        check("lo_523", lo, 956);

        // Silence code, then 0 Hz: no divide, note off at the next wrap
        tone = 32'd20000;
        seen = 0;
        n = 0;
        while (note_on === 1'b1 && n < LIMIT) begin
            if (busy === 1'b1) seen = 1;
            n++;
            @(negedge clk);
        end
        check("note_off_20000", note_on, 1'b0);
        check("pwm_off_20000", pwm, 1'b0);
        check("busy_seen_20000", seen, 0);
        tone = 32'd0;
        seen = 0;
        repeat (60) begin
            if (busy === 1'b1) seen = 1;
            @(negedge clk);
        end
        check("busy_seen_0hz", seen, 0);
        check("note_off_0hz", note_on, 1'b0);

        // Restart: 587 arrives 10 cycles into the 440 divide
        tone = 32'd440;
        wait_busy_high();
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            n++;
            if (n == 10) tone = 32'd587;
            @(negedge clk);
        end
        check("busy_len_restart", n, 65);
        wait_pwm(1'b1);
        check("period_587", dut.period_act_q, 32'd1703);
        count_pwm(1'b1, hi);
        count_pwm(1'b0, lo);
        check("hi_587", hi, 851);
        check("lo_587", lo, 852);

        // Disable while playing, retune to 698 while disabled
        en = 1'b0;
        @(negedge clk);
        check("pwm_en0", pwm, 1'b0);
        check("cnt_en0", dut.cnt_q, 32'd0);
        tone = 32'd698;
        repeat (50) @(negedge clk);
        check("period_698_dis", dut.period_act_q, 32'd1432);
        check("note_on_dis", note_on, 1'b1);
        check("pwm_dis", pwm, 1'b0);
        en = 1'b1;
        @(negedge clk);
        check("pwm_en1_start", pwm, 1'b1);
        count_pwm(1'b1, hi);
        count_pwm(1'b0, lo);
        check("hi_698", hi, 716);
        check("lo_698", lo, 716);

        // Highest audible tone with zero duty: note on, pwm silent
        duty = 10'd0;
        tone = 32'd19999;
        n = 0;
        while (dut.period_act_q !== 32'd50 && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        check("period_19999", dut.period_act_q, 32'd50);
        check("high_duty0", dut.high_act_q, 32'd0);
        check("note_on_duty0", note_on, 1'b1);
        seen = 0;
        repeat (120) begin
            if (pwm === 1'b1) seen = 1;
            @(negedge clk);
        end
        check("pwm_seen_duty0", seen, 0);

        // tone = 1 Hz gives the full dividend as period
        tone = 32'd1;
        count_busy(n);
        check("busy_len_1hz", n, 32);
        @(negedge clk);
        check("pend_1hz", dut.period_pend_q, 32'd1000000);

        // Asynchronous reset in the middle of a divide
        tone = 32'd440;
        wait_busy_high();
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_div_pwm", pwm, 1'b0);
        check("rst_div_busy", busy, 1'b0);
        check("rst_div_note_on", note_on, 1'b0);
        duty = 10'd512;
        @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        check("busy_len_after_rst", n, 32);
        wait_pwm(1'b1);
        count_pwm(1'b1, hi);
        count_pwm(1'b0, lo);
        check("hi_440_after_rst", hi, 1136);
        check("lo_440_after_rst", lo, 1136);

        // Asynchronous reset in the middle of a high phase
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_high_pwm", pwm, 1'b0);
        check("rst_high_busy", busy, 1'b0);
        check("rst_high_note_on", note_on, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        count_busy(n);
        check("busy_len_after_rst2", n, 32);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
